// File: rtl/cc_rsp_pkg.sv
// Shared types and helpers for the cache-controller read-response order scheduler.
package cc_rsp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic SRC_MEM = 1'b0;
  localparam logic SRC_HIT = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cc_order_queue.sv
// 1-bit order FIFO recording hit/miss of accepted requests; flags decode the registered occupancy.
module cc_order_queue
  import cc_rsp_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned AFULL_THRESHOLD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_push_data,
  input  logic i_pop,
  output logic o_head,
  output logic o_empty,
  output logic o_full,
  output logic o_afull,
  output logic o_overflow
);

  localparam int unsigned AW = cnt_width(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(AFULL_THRESHOLD);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == FULL_LVL);
  assign o_afull    = (r_count >= AFULL_LVL);
  assign o_head     = r_mem[r_rptr];
  assign w_pop_ok   = i_pop & ~o_empty;
  // A pop frees the slot this cycle, so a push into a full queue is still accepted.
  assign w_push_ok  = i_push & (~o_full | w_pop_ok);
  assign o_overflow = i_push & ~w_push_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cc_rsp_order_scheduler.sv
// Grants the INCT R channel to memory (miss) or serializer (hit) in request order,
// counting beats to generate last and checking each source's rlast against that count.
module cc_rsp_order_scheduler
  import cc_rsp_pkg::*;
#(
  parameter int unsigned ORDER_DEPTH     = 4,
  parameter int unsigned BURST_LEN       = 8,
  parameter int unsigned AFULL_THRESHOLD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ord_wren_i,
  input  logic ord_hit_i,
  output logic ord_full_o,
  output logic ord_afull_o,
  input  logic mem_rvalid_i,
  input  logic mem_rlast_i,
  output logic mem_rready_o,
  input  logic ser_rvalid_i,
  input  logic ser_rlast_i,
  output logic ser_rready_o,
  output logic out_sel_o,
  output logic out_valid_o,
  output logic out_last_o,
  input  logic out_ready_i,
  output logic busy_o,
  output logic err_o,
  input  logic err_clr_i
);

  localparam int unsigned CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_e        r_state;
  logic          r_cur_hit;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic w_empty;
  logic w_head;
  logic w_pop;
  logic w_overflow;
  logic w_in_burst;
  logic w_sel_hit;
  logic w_sel_valid;
  logic w_sel_last;
  logic w_is_last;
  logic w_hs;
  logic w_rlast_err;

  cc_order_queue #(
    .DEPTH           (ORDER_DEPTH),
    .AFULL_THRESHOLD (AFULL_THRESHOLD)
  ) u_order_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (ord_wren_i),
    .i_push_data (ord_hit_i),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (ord_full_o),
    .o_afull     (ord_afull_o),
    .o_overflow  (w_overflow)
  );

  assign w_in_burst  = (r_state == BURST);
  assign w_sel_hit   = (r_cur_hit == SRC_HIT);
  assign w_sel_valid = w_sel_hit ? ser_rvalid_i : mem_rvalid_i;
  assign w_sel_last  = w_sel_hit ? ser_rlast_i : mem_rlast_i;
  assign w_is_last   = (r_cnt == LAST_BEAT);

  // Valid comes from registered state and source valid only; never from ready.
  assign out_valid_o  = w_in_burst & w_sel_valid;
  assign out_last_o   = out_valid_o & w_is_last;
  assign out_sel_o    = w_in_burst & w_sel_hit;
  assign busy_o       = w_in_burst;
  assign mem_rready_o = w_in_burst & ~w_sel_hit & out_ready_i;
  assign ser_rready_o = w_in_burst & w_sel_hit & out_ready_i;
  assign err_o        = r_err;

  assign w_hs        = out_valid_o & out_ready_i;
  assign w_rlast_err = w_hs & (w_sel_last != w_is_last);
  assign w_pop       = ~w_empty & (~w_in_burst | (w_hs & w_is_last));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cur_hit <= SRC_MEM;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_cur_hit <= w_head;
            r_cnt     <= '0;
            r_state   <= BURST;
          end
        end
        BURST: begin
          if (w_hs) begin
            r_cnt <= w_is_last ? '0 : r_cnt + 1'b1;
            // Final beat chains straight into the next queued burst when one is waiting.
            if (w_is_last) begin
              if (!w_empty) begin
                r_cur_hit <= w_head;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_overflow | w_rlast_err) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule
